// File: rtl/anubis_pkg.sv
// Shared types and GF(2^8) helpers for the Anubis theta diffusion datapath.
// Field polynomial is x^8+x^4+x^3+x^2+1 (0x11D); only its low byte is needed for reduction.
package anubis_pkg;

    localparam logic [7:0] GF_POLY_LO = 8'h1D;
    localparam int         ROW_W      = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? GF_POLY_LO : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul4(input logic [7:0] b);
        gf_mul4 = xtime(xtime(b));
    endfunction

endpackage

// File: rtl/anubis_theta_row.sv
// One 32-bit row multiplied by the involutory MDS matrix H = [1 2 4 6; 2 1 6 4; 4 6 1 2; 6 4 2 1].
// Purely combinational; the shared pair sums let each output use one xtime and one gf_mul4.
module anubis_theta_row
    import anubis_pkg::*;
(
    input  logic [ROW_W-1:0] row,
    output logic [ROW_W-1:0] mixed
);

    logic [7:0] b0, b1, b2, b3;
    logic [7:0] s13, s02, s23, s01;
    logic [7:0] c0, c1, c2, c3;

    assign {b3, b2, b1, b0} = row;

    assign s13 = b1 ^ b3;
    assign s02 = b0 ^ b2;
    assign s23 = b2 ^ b3;
    assign s01 = b0 ^ b1;

    assign c0 = b0 ^ xtime(s13) ^ gf_mul4(s23);
    assign c1 = b1 ^ xtime(s02) ^ gf_mul4(s23);
    assign c2 = b2 ^ xtime(s13) ^ gf_mul4(s01);
    assign c3 = b3 ^ xtime(s02) ^ gf_mul4(s01);

    assign mixed = {c3, c2, c1, c0};

endmodule

// File: rtl/anubis_theta_pipe.sv
// Handshaked theta stage: one block register transformed in place, ROWS_PER_CYCLE rows per BUSY cycle.
// Bypassed blocks skip BUSY and are presented unchanged on the cycle after acceptance.
module anubis_theta_pipe
    import anubis_pkg::*;
#(
    parameter int  ROWS           = 4,
    parameter int  ROWS_PER_CYCLE = 4,
    localparam int DATA_W         = ROW_W * ROWS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_bypass,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    localparam int S     = ROWS / ROWS_PER_CYCLE;
    localparam int CNT_W = (S > 1) ? $clog2(S) : 1;

    if ((ROWS < 4) || (ROWS > 10) || (ROWS_PER_CYCLE < 1) ||
        ((ROWS % ROWS_PER_CYCLE) != 0)) begin : g_bad_cfg
        $error("anubis_theta_pipe: ROWS must be 4..10 and divisible by ROWS_PER_CYCLE");
    end

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   row_cnt, row_cnt_nxt;
    logic [DATA_W-1:0]  blk_p1, blk_nxt, blk_theta;
    logic               vld_p1;
    logic               accept;

    logic [ROW_W-1:0]   slice_rows [ROWS_PER_CYCLE];
    logic [ROW_W-1:0]   mixed_rows [ROWS_PER_CYCLE];

    // Slice mux: select the RPC rows addressed by row_cnt
    always_comb begin
        for (int i = 0; i < ROWS_PER_CYCLE; i++) begin
            slice_rows[i] = '0;
            for (int s = 0; s < S; s++) begin
                if (row_cnt == CNT_W'(s)) begin
                    slice_rows[i] = blk_p1[(s*ROWS_PER_CYCLE + i)*ROW_W +: ROW_W];
                end
            end
        end
    end

    for (genvar i = 0; i < ROWS_PER_CYCLE; i++) begin : g_row
        anubis_theta_row u_row (
            .row   (slice_rows[i]),
            .mixed (mixed_rows[i])
        );
    end

    // Write-back: only the addressed slice changes, the rest of the block is kept
    always_comb begin
        blk_theta = blk_p1;
        for (int s = 0; s < S; s++) begin
            for (int i = 0; i < ROWS_PER_CYCLE; i++) begin
                if (row_cnt == CNT_W'(s)) begin
                    blk_theta[(s*ROWS_PER_CYCLE + i)*ROW_W +: ROW_W] = mixed_rows[i];
                end
            end
        end
    end

    assign vld_p1    = (state == HOLD);
    assign in_ready  = !rst && ((state == IDLE) || ((state == HOLD) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = vld_p1;
    assign out_data  = blk_p1;

    always_comb begin
        state_nxt   = state;
        row_cnt_nxt = row_cnt;
        blk_nxt     = blk_p1;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    blk_nxt     = in_data;
                    row_cnt_nxt = '0;
                    state_nxt   = in_bypass ? HOLD : BUSY;
                end
            end
            BUSY: begin
                blk_nxt = blk_theta;
                if (row_cnt == CNT_W'(S - 1)) begin
                    row_cnt_nxt = '0;
                    state_nxt   = HOLD;
                end else begin
                    row_cnt_nxt = row_cnt + CNT_W'(1);
                end
            end
            HOLD: begin
                if (accept) begin
                    blk_nxt     = in_data;
                    row_cnt_nxt = '0;
                    state_nxt   = in_bypass ? HOLD : BUSY;
                end else if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt   = IDLE;
                row_cnt_nxt = '0;
            end
        endcase
    end

    // Block register stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            row_cnt <= '0;
            blk_p1  <= '0;
        end else begin
            state   <= state_nxt;
            row_cnt <= row_cnt_nxt;
            blk_p1  <= blk_nxt;
        end
    end

endmodule

// File: tb/tb_anubis_theta_pipe.sv
// Bench for anubis_theta_pipe: DUT 0 is ROWS=4/RPC=4, DUT 1 is ROWS=8/RPC=2.
// A transaction-level model (matrix product over GF(2^8), latency counter) is checked every cycle.
module tb_anubis_theta_pipe;

    localparam int MAXW = 256;
    localparam logic [7:0] HMAT [16] = '{8'd1, 8'd2, 8'd4, 8'd6,
                                         8'd2, 8'd1, 8'd6, 8'd4,
                                         8'd4, 8'd6, 8'd1, 8'd2,
                                         8'd6, 8'd4, 8'd2, 8'd1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      rst_v, iv, byp, ordy;
    logic [1:0]      ir, ov;
    logic [MAXW-1:0] din [2];
    logic [MAXW-1:0] dout [2];
    logic [127:0]    dout_a;
    logic [255:0]    dout_b;

    assign dout[0] = {128'b0, dout_a};
    assign dout[1] = dout_b;

    anubis_theta_pipe #(.ROWS(4), .ROWS_PER_CYCLE(4)) u_dut_a (
        .clk       (clk),
        .rst       (rst_v[0]),
        .in_valid  (iv[0]),
        .in_ready  (ir[0]),
        .in_data   (din[0][127:0]),
        .in_bypass (byp[0]),
        .out_valid (ov[0]),
        .out_ready (ordy[0]),
        .out_data  (dout_a)
    );

    anubis_theta_pipe #(.ROWS(8), .ROWS_PER_CYCLE(2)) u_dut_b (
        .clk       (clk),
        .rst       (rst_v[1]),
        .in_valid  (iv[1]),
        .in_ready  (ir[1]),
        .in_data   (din[1]),
        .in_bypass (byp[1]),
        .out_valid (ov[1]),
        .out_ready (ordy[1]),
        .out_data  (dout_b)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // Reference model
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1D) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [255:0] theta_blk(input logic [255:0] x, input int rows);
        logic [255:0] y;
        logic [7:0]   c;
        y = '0;
        for (int r = 0; r < rows; r++) begin
            for (int j = 0; j < 4; j++) begin
                c = 8'h00;
                for (int i = 0; i < 4; i++) c = c ^ gmul(HMAT[j*4+i], x[r*32+i*8 +: 8]);
                y[r*32+j*8 +: 8] = c;
            end
        end
        return y;
    endfunction

    function automatic logic [255:0] mask(input logic [255:0] x, input int rows);
        logic [255:0] m;
        m = (256'b1 << (rows*32)) - 256'b1;
        return x & m;
    endfunction

    function automatic int rows_of(input int d);
        return (d == 0) ? 4 : 8;
    endfunction

    function automatic int s_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic logic [255:0] rand_blk();
        logic [255:0] x;
        for (int i = 0; i < 8; i++) x[i*32 +: 32] = $urandom;
        return x;
    endfunction

    bit           m_pend  [2];
    bit           m_clean [2];
    int           m_left  [2];
    logic [255:0] m_data  [2];

    function automatic logic m_vld(input int d);
        return m_pend[d] && (m_left[d] == 0);
    endfunction

    function automatic logic m_ir(input int d);
        return !rst_v[d] && (!m_pend[d] || ((m_left[d] == 0) && ordy[d]));
    endfunction

    initial begin
        logic acc;
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                acc = iv[d] && m_ir(d);
                if (rst_v[d]) begin
                    m_pend[d] = 1'b0; m_left[d] = 0; m_data[d] = '0; m_clean[d] = 1'b1;
                end else if (acc) begin
                    m_pend[d]  = 1'b1;
                    m_clean[d] = 1'b0;
                    m_left[d]  = byp[d] ? 0 : s_of(d);
                    m_data[d]  = byp[d] ? mask(din[d], rows_of(d)) : theta_blk(din[d], rows_of(d));
                end else if (m_vld(d) && ordy[d]) begin
                    m_pend[d] = 1'b0;
                end else if (m_pend[d] && m_left[d] > 0) begin
                    m_left[d] = m_left[d] - 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int d = 0; d < 2; d++) begin
                    chk($sformatf("cyc_out_valid%0d", d), 256'(ov[d]), 256'(m_vld(d)));
                    chk($sformatf("cyc_in_ready%0d", d), 256'(ir[d]), 256'(m_ir(d)));
                    if (m_vld(d)) chk($sformatf("cyc_out_data%0d", d), dout[d], m_data[d]);
                    else if (m_clean[d]) chk($sformatf("cyc_out_zero%0d", d), dout[d], '0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [255:0] data, input logic b);
        din[d] = data; byp[d] = b; iv[d] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ir[d]) begin
                tick();
                iv[d] = 1'b0;
                return;
            end
        end
        iv[d] = 1'b0;
        total++; bad++;
        $display("FAIL send_timeout dut=%0d actual=no_accept required=accept", d);
    endtask

    task automatic wait_vld(input int d, output int n);
        n = 0;
        while (!ov[d] && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           n;
        logic [255:0] x, y, bb [6];

        rst_v = 2'b11; iv = 2'b00; byp = 2'b00; ordy = 2'b11;
        din[0] = '0; din[1] = '0;
        tick();
        chk_en = 1'b1;
        chk("rst_out_valid_a", 256'(ov[0]), 256'(0));
        chk("rst_in_ready_a", 256'(ir[0]), 256'(0));
        tick();
        rst_v = 2'b00;
        #1;
        chk("in_ready_after_rst_a", 256'(ir[0]), 256'(1));
        chk("in_ready_after_rst_b", 256'(ir[1]), 256'(1));

        // Model pins
        chk("model_unit", theta_blk({4{32'h00000001}}, 4), {128'h0, {4{32'h06040201}}});
        chk("model_reduce", theta_blk({4{32'h00000080}}, 4), {128'h0, {4{32'h273A1D80}}});
        chk("model_invol", theta_blk({4{32'h273A1D80}}, 4), {128'h0, {4{32'h00000080}}});

        // Unit vector
        send(0, {128'h0, {4{32'h00000001}}}, 1'b0);
        chk("unit_busy_valid", 256'(ov[0]), 256'(0));
        wait_vld(0, n);
        chk("unit_latency", 256'(n), 256'(1));
        chk("unit_data", dout[0], {128'h0, {4{32'h06040201}}});
        tick();

        // Reduction and involution
        send(0, {128'h0, {4{32'h00000080}}}, 1'b0);
        wait_vld(0, n);
        chk("reduce_latency", 256'(n), 256'(1));
        chk("reduce_data", dout[0], {128'h0, {4{32'h273A1D80}}});
        tick();
        send(0, {128'h0, {4{32'h273A1D80}}}, 1'b0);
        wait_vld(0, n);
        chk("invol_data", dout[0], {128'h0, {4{32'h00000080}}});
        tick();

        // Bypass, then back-to-back bypass
        x = mask(rand_blk(), 4);
        send(0, x, 1'b1);
        wait_vld(0, n);
        chk("byp_latency", 256'(n), 256'(0));
        chk("byp_data", dout[0], x);
        iv[0] = 1'b1; byp[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bb[k] = mask(rand_blk(), 4);
            din[0] = bb[k];
            tick();
            chk("b2b_valid", 256'(ov[0]), 256'(1));
            chk("b2b_data", dout[0], bb[k]);
        end
        iv[0] = 1'b0; byp[0] = 1'b0;
        tick();

        // Serialised mode
        for (int t = 0; t < 3; t++) begin
            x = rand_blk();
            send(1, x, 1'b0);
            chk("ser_busy_ready", 256'(ir[1]), 256'(0));
            wait_vld(1, n);
            chk("ser_latency", 256'(n), 256'(4));
            chk("ser_data", dout[1], theta_blk(x, 8));
            tick();
        end

        // Backpressure with a waiting block
        x = rand_blk();
        y = rand_blk();
        send(1, x, 1'b0);
        wait_vld(1, n);
        ordy[1] = 1'b0;
        din[1] = y; byp[1] = 1'b0; iv[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_stable", dout[1], theta_blk(x, 8));
            chk("bp_ready", 256'(ir[1]), 256'(0));
            chk("bp_valid", 256'(ov[1]), 256'(1));
        end
        ordy[1] = 1'b1;
        tick();
        iv[1] = 1'b0;
        chk("bp_swap_valid", 256'(ov[1]), 256'(0));
        wait_vld(1, n);
        chk("bp_new_latency", 256'(n), 256'(4));
        chk("bp_new_data", dout[1], theta_blk(y, 8));
        tick();

        // Reset in the middle of BUSY
        x = rand_blk();
        send(1, x, 1'b0);
        tick();
        rst_v[1] = 1'b1;
        tick();
        chk("mid_rst_valid", 256'(ov[1]), 256'(0));
        chk("mid_rst_data", dout[1], '0);
        chk("mid_rst_ready", 256'(ir[1]), 256'(0));
        rst_v[1] = 1'b0;
        #1;
        chk("post_rst_ready", 256'(ir[1]), 256'(1));
        y = rand_blk();
        send(1, y, 1'b0);
        wait_vld(1, n);
        chk("post_rst_latency", 256'(n), 256'(4));
        chk("post_rst_data", dout[1], theta_blk(y, 8));
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/anubis_theta_pipe.md
# anubis_theta_pipe

Parametrised, handshaked successor to the single-block combinational theta diffusion stage of the Anubis datapath. It holds one state block of ROWS 32-bit rows and multiplies each row by the involutory MDS matrix H = [1 2 4 6; 2 1 6 4; 4 6 1 2; 6 4 2 1] over GF(2^8) with polynomial 0x11D. It processes ROWS_PER_CYCLE rows per clock and supports a per-block bypass for the final round, which omits theta. It sits between the gamma/pi stages and the sigma key-addition stage, with valid/ready flow control on both sides.

## Interface
- ROWS, 4: rows per block, each 4 bytes; legal 4..10. DATA_W = 32*ROWS.
- ROWS_PER_CYCLE, 4: rows transformed per BUSY cycle; must divide ROWS, else elaboration error.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  an input block is offered.
- in_ready  out  1  the block accepts an input block this cycle.
- in_data  in  DATA_W  input block; row r at bits [32r+31:32r]; byte b0 of a row at bits [7:0], b3 at [31:24].
- in_bypass  in  1  sampled with in_data; 1 means pass the block unchanged (last round).
- out_valid  out  1  out_data is valid.
- out_ready  in  1  the downstream stage accepts out_data.
- out_data  out  DATA_W  diffused block, or the unchanged block when bypassed.

## Operation
- Per row: c0=b0^2(b1^b3)^4(b2^b3); c1=b1^2(b0^b2)^4(b2^b3); c2=b2^2(b1^b3)^4(b0^b1); c3=b3^2(b0^b2)^4(b0^b1).
- Multiplication by 2 is xtime: shift left 1; if the carry-out is 1, XOR the low byte with 0x1D. Multiplication by 4 is xtime applied twice. No ROMs.
- Applying the transform twice returns the input.
- Three-state FSM: IDLE, BUSY, HOLD. A single DATA_W block register is updated in place. row_cnt ranges over 0..S-1, where S = ROWS/ROWS_PER_CYCLE.
- IDLE: in_ready=1. On in_valid, capture in_data into the block register and clear row_cnt.
  - in_bypass=1: go to HOLD.
  - in_bypass=0: go to BUSY.
- BUSY: each cycle, replace rows [row_cnt*RPC .. row_cnt*RPC+RPC-1] with their transformed values and increment row_cnt. On the slice with row_cnt=S-1, go to HOLD. in_ready=0.
- HOLD: out_valid=1 and out_data is the block register.
  - out_ready=1 and in_valid=1: accept the new block at the same edge and go to BUSY or HOLD according to the new in_bypass.
  - out_ready=1 and in_valid=0: go to IDLE.
  - out_ready=0: stay in HOLD with out_data stable.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). It is combinational from out_ready; no other combinational input-to-output path exists.
- in_data and in_bypass are ignored whenever in_ready=0.

## Timing
- Reset, at the first edge with rst=1: state=IDLE, row_cnt=0, block register=0, out_valid=0, out_data=0. in_ready is forced to 0 while rst=1 and becomes 1 in the first cycle after rst deasserts.
- Reset mid-BUSY or mid-HOLD discards the block. No partial output is ever presented.
- Latency from the accept edge to the cycle where out_valid rises:
  - theta blocks: S+1 cycles. For ROWS=4 and RPC=4, accept at edge 0, BUSY during cycle 1, out_valid in cycle 2.
  - bypass blocks: 1 cycle.
- Throughput with out_ready held at 1: one theta block every S+1 cycles; one bypass block every cycle.
- While out_valid=1 and out_ready=0, out_data must not change.
- Simultaneous rst and handshake: rst wins; the handshake is not taken.

## Structure
- Package anubis_pkg contains:
  - GF_POLY_LO = 8'h1D;
  - ROW_W = 32;
  - functions xtime(byte) and gf_mul4(byte);
  - state enum {IDLE, BUSY, HOLD}.
- Sub-module anubis_theta_row: purely combinational, 32-bit row in, 32-bit row out. It is instantiated ROWS_PER_CYCLE times and fed from a row_cnt-indexed slice mux.
- The top level owns the FSM, row_cnt, block register and handshake logic.

## Test plan
- Unit vector, ROWS=4, RPC=4: every row = 0x00000001 -> every output row = 0x06040201, out_valid exactly 2 cycles after the accept edge.
- Reduction: every row = 0x00000080 -> every output row = 0x273A1D80. Feed that result back in -> every output row = 0x00000080, confirming the involution.
- Bypass: random block with in_bypass=1 -> out_data equals in_data bit-exactly, out_valid 1 cycle after accept; then back-to-back bypass blocks at 1 per cycle with out_ready held at 1.
- Serialised mode, ROWS=8, RPC=2: random blocks compared against a software model -> out_valid 5 cycles after accept, in_ready=0 throughout BUSY.
- Backpressure: hold out_ready=0 for 10 cycles in HOLD with in_valid=1 -> out_data stable, in_ready=0, no block lost. Release out_ready -> the new block is accepted on the same edge the old one leaves.
- Reset mid-BUSY (ROWS=8, RPC=2, rst at BUSY cycle 2) -> next cycle out_valid=0 and out_data=0; in_ready=1 after rst deasserts; the following block produces a correct result.
